rom_bus_arbiter: RTL

- Shares the single external ROM/SRAM port between three requesters: the SNES bus (already address-translated; ROM and SaveRAM mapping are resolved upstream), the Cx4 core's bus-master/cache-fill path, and the MCU.
- Sequences each granted access as a fixed-length SRAM cycle with OE/WE/DQ timing.
- Returns read data and a one-cycle ACK to the winner.
- SNES has absolute priority. Cx4 and MCU share the remaining slots round-robin.

---
 rtl/rom_bus_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: shares one external ROM/SRAM port between SNES, Cx4 and MCU.
// SNES (pulse, latched) has absolute priority; Cx4/MCU (level REQ) round-robin.
// Ports: CLK/RST; SNES_* pulse request side; CX4_*/MCU_* level request side;
// ROM_* external memory pins; BUSY high while an access is in progress.
module rom_bus_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int ADDR_W        = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SNES_REQ,
  input  logic              SNES_WE,
  input  logic [ADDR_W-1:0] SNES_ADDR_IN,
  input  logic [7:0]        SNES_DIN,
  output logic [7:0]        SNES_DOUT,
  output logic              SNES_ACK,
  input  logic              CX4_REQ,
  input  logic              CX4_WE,
  input  logic [ADDR_W-1:0] CX4_ADDR,
  input  logic [7:0]        CX4_DIN,
  output logic [7:0]        CX4_DOUT,
  output logic              CX4_ACK,
  input  logic              MCU_REQ,
  input  logic              MCU_WE,
  input  logic [ADDR_W-1:0] MCU_ADDR,
  input  logic [7:0]        MCU_DIN,
  output logic [7:0]        MCU_DOUT,
  output logic              MCU_ACK,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [7:0]        ROM_DQ_IN,
  output logic [7:0]        ROM_DQ_OUT,
  output logic              ROM_DQ_OE,
  output logic              ROM_OE_N,
  output logic              ROM_WE_N,
  output logic              BUSY
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [1:0] OWN_SNES = 2'd0;
  localparam logic [1:0] OWN_CX4  = 2'd1;
  localparam logic [1:0] OWN_MCU  = 2'd2;

  localparam logic [3:0] LAST    = 4'(ACCESS_CYCLES);
  localparam logic [3:0] LAST_M1 = 4'(ACCESS_CYCLES - 1);

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [1:0]        owner;
  logic              cur_we;
  logic              rr_mcu;

  logic              snes_pend;
  logic              snes_we_q;
  logic [ADDR_W-1:0] snes_addr_q;
  logic [7:0]        snes_din_q;

  logic              cx4_elig;
  logic              mcu_elig;
  logic              grant_snes;
  logic              grant_cx4;
  logic              grant_mcu;
  logic              grant_any;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [7:0]        win_din;

  // A requester is ignored during its own ACK cycle so one
  // held REQ cannot be granted twice.
  assign cx4_elig = CX4_REQ & ~CX4_ACK;
  assign mcu_elig = MCU_REQ & ~MCU_ACK;

  always_comb begin
    grant_snes = 1'b0;
    grant_cx4  = 1'b0;
    grant_mcu  = 1'b0;
    if (state == S_IDLE) begin
      if (snes_pend)
        grant_snes = 1'b1;
      else if (cx4_elig && (!rr_mcu || !mcu_elig))
        grant_cx4 = 1'b1;
      else if (mcu_elig)
        grant_mcu = 1'b1;
    end
  end

  assign grant_any = grant_snes | grant_cx4 | grant_mcu;

  always_comb begin
    win_addr = snes_addr_q;
    win_we   = snes_we_q;
    win_din  = snes_din_q;
    unique case (1'b1)
      grant_cx4: begin
        win_addr = CX4_ADDR;
        win_we   = CX4_WE;
        win_din  = CX4_DIN;
      end
      grant_mcu: begin
        win_addr = MCU_ADDR;
        win_we   = MCU_WE;
        win_din  = MCU_DIN;
      end
      default: ;
    endcase
  end

  // A new pulse wins over the clear, so a pulse on the grant
  // edge of the previous SNES request stays pending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snes_pend   <= 1'b0;
      snes_we_q   <= 1'b0;
      snes_addr_q <= '0;
      snes_din_q  <= 8'h00;
    end else if (SNES_REQ) begin
      snes_pend   <= 1'b1;
      snes_we_q   <= SNES_WE;
      snes_addr_q <= SNES_ADDR_IN;
      snes_din_q  <= SNES_DIN;
    end else if (grant_snes) begin
      snes_pend <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      owner      <= OWN_SNES;
      cur_we     <= 1'b0;
      rr_mcu     <= 1'b0;
      ROM_ADDR   <= '0;
      ROM_DQ_OUT <= 8'h00;
      SNES_ACK   <= 1'b0;
      CX4_ACK    <= 1'b0;
      MCU_ACK    <= 1'b0;
      SNES_DOUT  <= 8'h00;
      CX4_DOUT   <= 8'h00;
      MCU_DOUT   <= 8'h00;
    end else begin
      SNES_ACK <= 1'b0;
      CX4_ACK  <= 1'b0;
      MCU_ACK  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_any) begin
            ROM_ADDR   <= win_addr;
            ROM_DQ_OUT <= win_din;
            cur_we     <= win_we;
            state      <= S_ACCESS;
            cnt        <= 4'd1;
            unique case (1'b1)
              grant_cx4: begin
                owner  <= OWN_CX4;
                rr_mcu <= 1'b1;
              end
              grant_mcu: begin
                owner  <= OWN_MCU;
                rr_mcu <= 1'b0;
              end
              default: owner <= OWN_SNES;
            endcase
          end
        end
        default: begin
          if (cnt == LAST) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            unique case (owner)
              OWN_CX4: begin
                CX4_ACK <= 1'b1;
                if (!cur_we) CX4_DOUT <= ROM_DQ_IN;
              end
              OWN_MCU: begin
                MCU_ACK <= 1'b1;
                if (!cur_we) MCU_DOUT <= ROM_DQ_IN;
              end
              default: begin
                SNES_ACK <= 1'b1;
                if (!cur_we) SNES_DOUT <= ROM_DQ_IN;
              end
            endcase
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Strobes decode straight from registered state so reset
  // releases the bus asynchronously.
  assign BUSY      = (state == S_ACCESS);
  assign ROM_OE_N  = ~(BUSY & ~cur_we);
  assign ROM_DQ_OE = BUSY & cur_we;
  // First and last access cycles give address setup and hold.
  assign ROM_WE_N  = ~(BUSY & cur_we &
                       (cnt >= 4'd2) & (cnt <= LAST_M1));

endmodule
